// File: rtl/ad7276_pkg.sv
// Shared types and frame-layout constants for the AD7276 serial capture block.
package ad7276_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    localparam int unsigned AD7276_FRAME_BITS = 16;
    localparam int unsigned AD7276_MSB        = 13;
    localparam int unsigned AD7276_LSB        = 2;

endpackage

// File: rtl/ad7276_sclk_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, cleared when disabled.
module ad7276_sclk_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic rstn,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CNT_MAX);

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ad7276_capture.sv
// AD7276 serial front end: drives CS_n/SCLK, shifts in one 16-bit frame per request and
// presents the 12-bit sample on a single-entry AXI4-Stream output register.
module ad7276_capture
    import ad7276_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned FRAME_BITS   = AD7276_FRAME_BITS,
    parameter int unsigned QUIET_CYCLES = 4,
    parameter int unsigned TDATA_WIDTH  = 16
) (
    input  logic                   clk_in,
    input  logic                   rstn,
    input  logic                   conv_start,
    output logic                   busy,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    input  logic                   adc_sdata,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   overrun
);

    localparam int unsigned BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [QUIET_W-1:0]       r_quiet_cnt;
    // Leading zero bits fall off the top; only D11..D0 and the trailing bits are kept.
    logic [AD7276_MSB:0]      r_shreg;
    logic                     r_cs_n;
    logic                     r_sclk;
    logic [TDATA_WIDTH-1:0]   r_tdata;
    logic                     r_tvalid;
    logic                     r_overrun;

    logic w_tick_en;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_last_fall;
    logic w_quiet_done;
    logic w_load;

    assign w_tick_en = (r_state == SETUP) || (r_state == SHIFT);

    ad7276_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_tick (
        .clk_in (clk_in),
        .rstn   (rstn),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    assign w_rise       = (r_state == SHIFT) && w_tick && !r_sclk;
    assign w_fall       = (r_state == SHIFT) && w_tick && r_sclk;
    assign w_last_fall  = w_fall && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign w_quiet_done = (r_state == QUIET) && (r_quiet_cnt == QUIET_W'(QUIET_CYCLES - 1));
    assign w_load       = (r_state == QUIET) && (r_quiet_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (conv_start)   w_state_next = SETUP;
            SETUP:   if (w_tick)       w_state_next = SHIFT;
            SHIFT:   if (w_last_fall)  w_state_next = QUIET;
            QUIET:   if (w_quiet_done) w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    // The tick that would produce the 17th fall ends the frame, leaving SCLK high.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_bit_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_shreg     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cs_n  <= (w_state_next != SETUP) && (w_state_next != SHIFT);
            if ((r_state == SETUP) && w_tick) begin
                r_sclk <= 1'b0;
            end else if (w_rise) begin
                r_sclk <= 1'b1;
            end else if (w_fall && !w_last_fall) begin
                r_sclk <= 1'b0;
            end
            if (w_last_fall) begin
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_rise) begin
                r_shreg <= {r_shreg[AD7276_MSB-1:0], adc_sdata};
            end
            if (w_quiet_done) begin
                r_quiet_cnt <= '0;
            end else if (r_state == QUIET) begin
                r_quiet_cnt <= r_quiet_cnt + QUIET_W'(1);
            end
        end
    end

    // A new sample wins over a same-cycle handshake; otherwise a full register drops it.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_load && r_tvalid && !m_axis_tready;
            if (w_load && (!r_tvalid || m_axis_tready)) begin
                r_tdata  <= TDATA_WIDTH'(r_shreg[AD7276_MSB:AD7276_LSB]);
                r_tvalid <= 1'b1;
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign adc_cs_n      = r_cs_n;
    assign adc_sclk      = r_sclk;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_ad7276_capture.sv
// Bench for ad7276_capture: ADC serial model, AXIS beat scoreboard and directed/random frames
// on a CLK_DIV=2 instance and a CLK_DIV=1 instance.
module tb_ad7276_capture;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        conv_start    = 1'b0;
    logic        busy;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdata     = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        overrun;

    logic        conv_start1    = 1'b0;
    logic        busy1;
    logic        adc_cs_n1;
    logic        adc_sclk1;
    logic        adc_sdata1     = 1'b0;
    logic [15:0] m_axis_tdata1;
    logic        m_axis_tvalid1;
    logic        m_axis_tready1 = 1'b1;
    logic        overrun1;

    ad7276_capture #(
        .CLK_DIV(2), .FRAME_BITS(16), .QUIET_CYCLES(4), .TDATA_WIDTH(16)
    ) u_dut (
        .clk_in(clk), .rstn(rstn), .conv_start(conv_start), .busy(busy),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdata(adc_sdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .overrun(overrun)
    );

    ad7276_capture #(
        .CLK_DIV(1), .FRAME_BITS(16), .QUIET_CYCLES(4), .TDATA_WIDTH(16)
    ) u_dut1 (
        .clk_in(clk), .rstn(rstn), .conv_start(conv_start1), .busy(busy1),
        .adc_cs_n(adc_cs_n1), .adc_sclk(adc_sclk1), .adc_sdata(adc_sdata1),
        .m_axis_tdata(m_axis_tdata1), .m_axis_tvalid(m_axis_tvalid1),
        .m_axis_tready(m_axis_tready1), .overrun(overrun1)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // ADC model: first bit presented on the first SCLK fall, next bit on each later fall.
    logic [15:0] adc_word  = 16'h0000;
    logic [15:0] adc_word1 = 16'h0000;
    int          adc_idx   = 0;
    int          adc_idx1  = 0;

    always @(negedge adc_cs_n) adc_idx = 0;
    always @(negedge adc_sclk) begin
        if (!adc_cs_n && adc_idx < 16) begin
            adc_sdata = adc_word[15 - adc_idx];
            adc_idx++;
        end
    end

    time cs1_fall_t = 0;
    time rise1_t[$];
    always @(negedge adc_cs_n1) begin
        adc_idx1   = 0;
        cs1_fall_t = $time;
    end
    always @(negedge adc_sclk1) begin
        if (!adc_cs_n1 && adc_idx1 < 16) begin
            adc_sdata1 = adc_word1[15 - adc_idx1];
            adc_idx1++;
        end
    end
    always @(posedge adc_sclk1) if (!adc_cs_n1) rise1_t.push_back($time);

    int          busy_cnt  = 0;
    int          ovr_cnt   = 0;
    int          rise_cnt  = 0;
    int          busy1_cnt = 0;
    logic [15:0] beats[$];
    logic [15:0] beats1[$];

    always @(posedge adc_sclk) if (!adc_cs_n) rise_cnt++;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (overrun) ovr_cnt++;
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
        if (busy1) busy1_cnt++;
        if (m_axis_tvalid1 && m_axis_tready1) beats1.push_back(m_axis_tdata1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Reference: the sample is the 12 bits after the two leading frame bits.
    function automatic logic [15:0] model_sample(input logic [15:0] word);
        return (word >> 2) & 16'h0FFF;
    endfunction

    function automatic logic [15:0] mk_word(input logic [11:0] s);
        return {2'b00, s, 2'b00};
    endfunction

    function automatic logic [15:0] beat_at(input int i);
        if (i < beats.size()) return beats[i];
        return 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        busy_cnt = 0;
        ovr_cnt  = 0;
        rise_cnt = 0;
        beats.delete();
    endtask

    // Cycle 1 is the first cycle after conv_start is taken; optional extra conv_start and a
    // one-cycle tready pulse land in the given cycle numbers.
    task automatic run_frame(input logic [15:0] word, input int restart_at, input int ready_at);
        int c;
        adc_word   = word;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        c = 1;
        while (busy && c < 300) begin
            tick();
            c++;
            conv_start = (c == restart_at);
            if (ready_at > 0) m_axis_tready = (c == ready_at);
        end
        conv_start = 1'b0;
        check("frame_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int          c;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",   {31'd0, adc_cs_n},      32'd1);
        check("rst_sclk",   {31'd0, adc_sclk},      32'd1);
        check("rst_busy",   {31'd0, busy},          32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata",  {16'd0, m_axis_tdata},  32'd0);
        check("rst_ovr",    {31'd0, overrun},       32'd0);
        rstn = 1'b1;
        tick();

        // Basic frame, tready held high.
        m_axis_tready = 1'b1;
        clear_mon();
        run_frame(16'h1ABC, 0, 0);
        repeat (4) tick();
        check("s1_beats", beats.size(), 1);
        check("s1_tdata", {16'd0, beat_at(0)}, 32'h06AF);
        check("s1_busy",  busy_cnt, 70);
        check("s1_rises", rise_cnt, 16);
        check("s1_ovr",   ovr_cnt, 0);

        // conv_start while busy, including the last busy cycle, is dropped.
        w = 16'($urandom);
        clear_mon();
        run_frame(w, 10, 0);
        repeat (4) tick();
        check("s2_beats", beats.size(), 1);
        check("s2_tdata", {16'd0, beat_at(0)}, {16'd0, model_sample(w)});
        check("s2_busy",  busy_cnt, 70);
        w = 16'($urandom);
        clear_mon();
        run_frame(w, 70, 0);
        repeat (3) tick();
        check("s2_edge_idle", {31'd0, busy}, 32'd0);
        check("s2_edge_busy", busy_cnt, 70);

        // Output register full: second sample dropped with a single overrun pulse.
        m_axis_tready = 1'b0;
        repeat (2) tick();
        clear_mon();
        run_frame(mk_word(12'h123), 0, 0);
        repeat (2) tick();
        check("s3_tvalid1", {31'd0, m_axis_tvalid}, 32'd1);
        check("s3_tdata1",  {16'd0, m_axis_tdata},  32'h0123);
        run_frame(mk_word(12'h456), 0, 0);
        repeat (2) tick();
        check("s3_ovr",    ovr_cnt, 1);
        check("s3_hold",   {16'd0, m_axis_tdata}, 32'h0123);
        check("s3_nobeat", beats.size(), 0);
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("s3_beats",  beats.size(), 1);
        check("s3_beat0",  {16'd0, beat_at(0)}, 32'h0123);
        check("s3_drain",  {31'd0, m_axis_tvalid}, 32'd0);

        // Handshake in the load cycle: old beat accepted and new one loaded together.
        m_axis_tready = 1'b0;
        tick();
        clear_mon();
        run_frame(mk_word(12'h123), 0, 0);
        run_frame(mk_word(12'h456), 0, 67);
        repeat (2) tick();
        check("s4_beats",  beats.size(), 1);
        check("s4_beat0",  {16'd0, beat_at(0)}, 32'h0123);
        check("s4_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check("s4_tdata",  {16'd0, m_axis_tdata}, 32'h0456);
        check("s4_ovr",    ovr_cnt, 0);
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("s4_beat1",  {16'd0, beat_at(1)}, 32'h0456);

        // Reset after the 7th SCLK rise with a beat held.
        m_axis_tready = 1'b0;
        tick();
        run_frame(16'($urandom), 0, 0);
        clear_mon();
        adc_word   = 16'($urandom);
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        c = 0;
        while (rise_cnt < 7 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("s5_rise7", rise_cnt, 7);
        #1 rstn = 1'b0;
        #1;
        check("s5_cs_n",   {31'd0, adc_cs_n},      32'd1);
        check("s5_sclk",   {31'd0, adc_sclk},      32'd1);
        check("s5_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("s5_busy",   {31'd0, busy},          32'd0);
        tick();
        rstn = 1'b1;
        tick();
        m_axis_tready = 1'b1;
        w = 16'($urandom);
        clear_mon();
        run_frame(w, 0, 0);
        repeat (4) tick();
        check("s5_beats", beats.size(), 1);
        check("s5_tdata", {16'd0, beat_at(0)}, {16'd0, model_sample(w)});
        check("s5_ovr",   ovr_cnt, 0);

        // Random frames, random leading/trailing bits.
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            clear_mon();
            run_frame(w, 0, 0);
            repeat (3) tick();
            check("rnd_beats", beats.size(), 1);
            check("rnd_tdata", {16'd0, beat_at(0)}, {16'd0, model_sample(w)});
        end

        // CLK_DIV=1 instance, sdata all ones.
        adc_word1 = 16'hFFFF;
        rise1_t.delete();
        beats1.delete();
        busy1_cnt   = 0;
        conv_start1 = 1'b1;
        tick();
        conv_start1 = 1'b0;
        c = 1;
        while (busy1 && c < 300) begin
            tick();
            c++;
        end
        check("s6_done", {31'd0, busy1}, 32'd0);
        repeat (3) tick();
        check("s6_beats", beats1.size(), 1);
        check("s6_tdata", (beats1.size() > 0) ? {16'd0, beats1[0]} : 32'hxxxx, 32'h0FFF);
        check("s6_busy",  busy1_cnt, 37);
        check("s6_rises", rise1_t.size(), 16);
        if (rise1_t.size() >= 2) begin
            check("s6_period", int'(rise1_t[1] - rise1_t[0]), 20);
            check("s6_first",  int'(rise1_t[0] - cs1_fall_t), 20);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
